// File: rtl/ysyx_22050078_mem_arb.sv
// Two-requester (ifu/lsu) arbiter in front of a single pmem read port, one transaction in flight.
// Define YSYX_22050078_ARB_RR_EN for round-robin grants; otherwise lsu has fixed priority.
module ysyx_22050078_mem_arb #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_req_ready,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  output logic              lsu_req_ready,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              arb_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [7:0] TO_CYC = 8'(TIMEOUT_CYC);

  state_e            state_q;
  logic              owner_q;          // 1: lsu owns the transaction
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        cnt_q;
  logic              mem_req_valid_q;
  logic              ifu_resp_valid_q;
  logic              lsu_resp_valid_q;
  logic              arb_timeout_q;
  logic [DATA_W-1:0] ifu_resp_data_q;
  logic [DATA_W-1:0] lsu_resp_data_q;

  logic              grant_lsu_d;
  logic              accept_d;
  logic [7:0]        cnt_inc_d;
  logic              timeout_d;
  logic              finish_d;
  logic [DATA_W-1:0] resp_word_d;

`ifdef YSYX_22050078_ARB_RR_EN
  logic last_q;                        // 1: lsu was served last
  // On a tie the requester that was not served last wins.
  assign grant_lsu_d = lsu_req_valid && (!ifu_req_valid || !last_q);
`else
  assign grant_lsu_d = lsu_req_valid;
`endif

  assign accept_d      = (state_q == IDLE) && !rst && (ifu_req_valid || lsu_req_valid);
  assign ifu_req_ready = accept_d && !grant_lsu_d;
  assign lsu_req_ready = accept_d && grant_lsu_d;

  always_comb begin
    cnt_inc_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    timeout_d   = (state_q == RESP) && !mem_resp_valid && (cnt_inc_d == TO_CYC);
    finish_d    = (state_q == RESP) && (mem_resp_valid || timeout_d);
    resp_word_d = timeout_d ? '0 : mem_resp_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      owner_q          <= 1'b0;
      addr_q           <= '0;
      cnt_q            <= '0;
      mem_req_valid_q  <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      arb_timeout_q    <= 1'b0;
      ifu_resp_data_q  <= '0;
      lsu_resp_data_q  <= '0;
`ifdef YSYX_22050078_ARB_RR_EN
      last_q           <= 1'b0;
`endif
    end else begin
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      arb_timeout_q    <= 1'b0;
      if (finish_d) begin
        arb_timeout_q <= timeout_d;
        if (owner_q) begin
          lsu_resp_valid_q <= 1'b1;
          lsu_resp_data_q  <= resp_word_d;
        end else begin
          ifu_resp_valid_q <= 1'b1;
          ifu_resp_data_q  <= resp_word_d;
        end
      end
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            addr_q          <= grant_lsu_d ? lsu_req_addr : ifu_req_addr;
            owner_q         <= grant_lsu_d;
            mem_req_valid_q <= 1'b1;
            state_q         <= REQ;
`ifdef YSYX_22050078_ARB_RR_EN
            last_q          <= grant_lsu_d;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            cnt_q           <= '0;
            state_q         <= RESP;
          end
        end
        RESP: begin
          if (finish_d) state_q <= IDLE;
          else          cnt_q   <= cnt_inc_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = addr_q;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_data_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_resp_data  = lsu_resp_data_q;
  assign arb_timeout    = arb_timeout_q;

endmodule

// File: tb/tb_ysyx_22050078_mem_arb.sv
// Randomized bench for ysyx_22050078_mem_arb: a transaction-schedule model predicts every output each cycle.
module tb_ysyx_22050078_mem_arb;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, lsu_req_valid, mem_req_ready, mem_resp_valid;
  logic [AW-1:0] ifu_req_addr, lsu_req_addr;
  logic [DW-1:0] mem_resp_data;
  logic          ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid;
  logic          mem_req_valid, arb_timeout;
  logic [DW-1:0] ifu_resp_data, lsu_resp_data;
  logic [AW-1:0] mem_req_addr;

  always #5 clk = ~clk;

  ysyx_22050078_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .arb_timeout(arb_timeout)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending requests per requester, who was served last, and the expected outputs for this cycle.
  bit            ifu_pend, lsu_pend, last_lsu, rnd_en, chk_en;
  logic [AW-1:0] ifu_a, lsu_a;
  bit            exp_ifu_ready, exp_lsu_ready, exp_mem_v, exp_ifu_rv, exp_lsu_rv, exp_to;
  logic [AW-1:0] exp_mem_addr;
  logic [DW-1:0] exp_ifu_rd, exp_lsu_rd;
  bit            pend_ifu_pulse, pend_lsu_pulse, pend_to, pend_zero;
  logic [DW-1:0] pend_data;

  int            grant_q[$];
  int            mv_run = 0, mv_last = 0;
  logic [AW-1:0] mv_addr;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ifu_req_ready", 64'(ifu_req_ready), 64'(exp_ifu_ready));
      chk("lsu_req_ready", 64'(lsu_req_ready), 64'(exp_lsu_ready));
      chk("mem_req_valid", 64'(mem_req_valid), 64'(exp_mem_v));
      if (exp_mem_v) chk("mem_req_addr", mem_req_addr, exp_mem_addr);
      chk("ifu_resp_valid", 64'(ifu_resp_valid), 64'(exp_ifu_rv));
      chk("lsu_resp_valid", 64'(lsu_resp_valid), 64'(exp_lsu_rv));
      chk("ifu_resp_data", ifu_resp_data, exp_ifu_rd);
      chk("lsu_resp_data", lsu_resp_data, exp_lsu_rd);
      chk("arb_timeout", 64'(arb_timeout), 64'(exp_to));
    end
  end

  always @(negedge clk) begin
    if (lsu_req_ready) grant_q.push_back(1);
    else if (ifu_req_ready) grant_q.push_back(0);
    if (mem_req_valid) begin
      mv_run++;
      mv_addr = mem_req_addr;
    end else if (mv_run != 0) begin
      mv_last = mv_run;
      mv_run = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Opens a cycle at posedge+1: applies pulses scheduled by the previous edge and drives default stimulus.
  task automatic begin_cycle();
    exp_ifu_rv = pend_ifu_pulse;
    exp_lsu_rv = pend_lsu_pulse;
    exp_to     = pend_to;
    if (pend_ifu_pulse) exp_ifu_rd = pend_data;
    if (pend_lsu_pulse) exp_lsu_rd = pend_data;
    if (pend_zero) begin
      exp_ifu_rd = '0;
      exp_lsu_rd = '0;
    end
    pend_ifu_pulse = 0; pend_lsu_pulse = 0; pend_to = 0; pend_zero = 0;
    exp_ifu_ready = 0; exp_lsu_ready = 0; exp_mem_v = 0;
    rst = 1'b0;
    if (rnd_en) begin
      if (!ifu_pend && $urandom_range(0, 2) == 0) begin
        ifu_pend = 1; ifu_a = {32'd0, 32'h8000_0000 | ($urandom & 32'h0000_fffc)};
      end
      if (!lsu_pend && $urandom_range(0, 2) == 0) begin
        lsu_pend = 1; lsu_a = {32'd0, 32'h8001_0000 | ($urandom & 32'h0000_fff8)};
      end
    end
    ifu_req_valid  = ifu_pend;
    ifu_req_addr   = ifu_pend ? ifu_a : {$urandom, $urandom};
    lsu_req_valid  = lsu_pend;
    lsu_req_addr   = lsu_pend ? lsu_a : {$urandom, $urandom};
    mem_req_ready  = 1'($urandom_range(0, 1));
    mem_resp_valid = rnd_en && ($urandom_range(0, 7) == 0);
    mem_resp_data  = {$urandom, $urandom};
  endtask

  // One full transaction: rd = cycles of mem_req_ready low, sd = RESP cycle carrying the response
  // (sd > TO means none), rst_k = RESP cycle in which reset is asserted (0 = never).
  task automatic txn(int rd, int sd, logic [DW-1:0] rdata, int rst_k);
    int guard;
    bit own_lsu;
    guard = 0;
    begin_cycle();
    while (!ifu_pend && !lsu_pend) begin
      step();
      guard++;
      if (guard > 100) begin
        checks++; errors++;
        $display("FAIL accept_wait: got no request after %0d cycles, expected one", guard);
        return;
      end
      begin_cycle();
    end
`ifdef YSYX_22050078_ARB_RR_EN
    own_lsu = (ifu_pend && lsu_pend) ? !last_lsu : lsu_pend;
`else
    own_lsu = lsu_pend;
`endif
    last_lsu = own_lsu;
    if (own_lsu) begin
      exp_lsu_ready = 1; exp_mem_addr = lsu_a; lsu_pend = 0;
    end else begin
      exp_ifu_ready = 1; exp_mem_addr = ifu_a; ifu_pend = 0;
    end
    step();
    for (int k = 0; k <= rd; k++) begin
      begin_cycle();
      exp_mem_v = 1;
      mem_req_ready = (k == rd);
      step();
    end
    for (int k = 1; k <= TO; k++) begin
      begin_cycle();
      if (k == rst_k) begin
        rst = 1'b1; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; mem_resp_valid = 1'b0;
        pend_zero = 1; last_lsu = 0;
        step();
        begin_cycle();
        mem_resp_valid = 1'b1; mem_resp_data = rdata;
        step();
        return;
      end
      if (k == sd) begin
        mem_resp_valid = 1'b1; mem_resp_data = rdata;
        pend_data = rdata;
        if (own_lsu) pend_lsu_pulse = 1; else pend_ifu_pulse = 1;
        step();
        return;
      end
      mem_resp_valid = 1'b0;
      if (k == TO) begin
        pend_data = '0; pend_to = 1;
        if (own_lsu) pend_lsu_pulse = 1; else pend_ifu_pulse = 1;
      end
      step();
    end
  endtask

  task automatic idle(bit resp);
    begin_cycle();
    if (resp) begin
      mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD_BEEF_0000_0001;
    end
    step();
  endtask

  initial begin
    rst = 1'b1; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_req_addr = 64'h8000_0000; lsu_req_addr = 64'h8000_1000;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    exp_ifu_rd = '0; exp_lsu_rd = '0; exp_mem_addr = '0; last_lsu = 0;
    step();
    chk_en = 1;
    chk("rst_mem_addr", mem_req_addr, 64'h0);
    step();
    step();

    // Single ifu fetch with minimum latency.
    ifu_pend = 1; ifu_a = 64'h8000_0000;
    txn(0, 1, 64'h0000_0413, 0);
    chk("fetch_rv", 64'(ifu_resp_valid), 64'h1);
    chk("fetch_data", ifu_resp_data, 64'h0000_0413);
    chk("fetch_lsu_rv", 64'(lsu_resp_valid), 64'h0);

    // Simultaneous requests, then lsu alone, then simultaneous again.
    grant_q.delete();
    ifu_pend = 1; ifu_a = 64'h8000_0004; lsu_pend = 1; lsu_a = 64'h8000_1000;
    txn(0, 1, 64'h0000_00AA, 0);
    txn(0, 2, 64'h0000_00BB, 0);
    lsu_pend = 1; lsu_a = 64'h8000_1008;
    txn(1, 1, 64'h0000_00CC, 0);
    ifu_pend = 1; ifu_a = 64'h8000_0010; lsu_pend = 1; lsu_a = 64'h8000_1010;
    txn(0, 1, 64'h0000_00DD, 0);
    txn(0, 1, 64'h0000_00EE, 0);
    chk("grant_count", 64'(grant_q.size()), 64'd5);
    if (grant_q.size() == 5) begin
      chk("grant_first_lsu", 64'(grant_q[0]), 64'd1);
      chk("grant_second_ifu", 64'(grant_q[1]), 64'd0);
`ifdef YSYX_22050078_ARB_RR_EN
      chk("grant_after_lsu", 64'(grant_q[3]), 64'd0);
`else
      chk("grant_after_lsu", 64'(grant_q[3]), 64'd1);
`endif
    end

    // Backpressure: ready low for 10 cycles.
    ifu_pend = 1; ifu_a = 64'h8000_0008;
    txn(10, 1, 64'h1111_2222_3333_4444, 0);
    chk("bp_valid_cycles", 64'(mv_last), 64'd11);
    chk("bp_addr", mv_addr, 64'h8000_0008);

    // Timeout, then a late response two cycles later.
    ifu_pend = 1; ifu_a = 64'h8000_000C;
    txn(0, TO + 2, 64'h5555, 0);
    chk("to_rv", 64'(ifu_resp_valid), 64'h1);
    chk("to_data", ifu_resp_data, 64'h0);
    chk("to_pulse", 64'(arb_timeout), 64'h1);
    idle(0);
    idle(1);
    chk("late_ifu_rv", 64'(ifu_resp_valid), 64'h0);
    chk("late_lsu_rv", 64'(lsu_resp_valid), 64'h0);

    // Reset in the middle of RESP, then a stray response, then a normal request.
    lsu_pend = 1; lsu_a = 64'h8000_2000;
    txn(0, 3, 64'h6666, 2);
    chk("rst_mid_addr", mem_req_addr, 64'h0);
    chk("rst_mid_lsu_rv", 64'(lsu_resp_valid), 64'h0);
    chk("rst_mid_ifu_data", ifu_resp_data, 64'h0);
    ifu_pend = 1; ifu_a = 64'h8000_0020;
    txn(1, 2, 64'h7777, 0);
    chk("post_rst_rv", 64'(ifu_resp_valid), 64'h1);
    chk("post_rst_data", ifu_resp_data, 64'h7777);

    // Randomized traffic, including spurious responses and timeouts.
    rnd_en = 1;
    repeat (150) txn($urandom_range(0, 3), $urandom_range(1, TO + 2), {$urandom, $urandom}, 0);
    rnd_en = 0;
    while (ifu_pend || lsu_pend) txn(0, 1, {$urandom, $urandom}, 0);
    idle(0);
    idle(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22050078_mem_arb.md
YSYX_22050078_MEM_ARB -- requirements
Module: ysyx_22050078_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 64: request address width in bits (CPU_WIDTH).
REQ-002 SHALL have parameter DATA_W, default 64: memory read data width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: maximum wait for a response, in cycles, counted in RESP; legal range 1..255.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have ports ifu_req_valid (input, 1), ifu_req_addr (input, ADDR_W) and ifu_req_ready (output, 1): instruction-fetch request handshake.
REQ-007 SHALL have ports ifu_resp_valid (output, 1) and ifu_resp_data (output, DATA_W): instruction-fetch response.
REQ-008 SHALL have ports lsu_req_valid (input, 1), lsu_req_addr (input, ADDR_W) and lsu_req_ready (output, 1): load request handshake.
REQ-009 SHALL have ports lsu_resp_valid (output, 1) and lsu_resp_data (output, DATA_W): load response.
REQ-010 SHALL have ports mem_req_valid (output, 1), mem_req_addr (output, ADDR_W) and mem_req_ready (input, 1): shared pmem read port request.
REQ-011 SHALL have ports mem_resp_valid (input, 1) and mem_resp_data (input, DATA_W): shared pmem read response.
REQ-012 SHALL have port arb_timeout (output, 1): one-cycle pulse when a transaction times out.

Function
REQ-013 SHALL implement FSM states IDLE, REQ and RESP, with at most one memory transaction outstanding.
REQ-014 IDLE SHALL arbitrate when any req_valid is high: exactly one winner gets req_ready=1 in the same cycle (combinational from req_valid); the FSM latches the address and owner, then moves to REQ.
REQ-015 req_ready SHALL be 0 in REQ and RESP, and 0 for the losing requester.
REQ-016 REQ SHALL drive mem_req_valid=1 with the latched address held stable; on mem_req_ready=1 it moves to RESP.
REQ-017 REQ SHALL have no timeout and SHALL ignore mem_resp_valid.
REQ-018 RESP SHALL move to IDLE on mem_resp_valid=1.
REQ-019 On that same edge, RESP SHALL register mem_resp_data into the owner's resp_data and pulse the owner's resp_valid for exactly one cycle.
REQ-020 The non-owner resp_valid SHALL remain 0.
REQ-021 Minimum latency SHALL be: accept at T, mem_req_valid at T+1, and with ready at T+1 and response at T+2, owner resp_valid at T+3.
REQ-022 A new request SHALL be acceptable in the same cycle a resp_valid pulse is driven, because the FSM is in IDLE.
REQ-023 The RESP wait counter SHALL be 8 bits wide, clear on entry to RESP and saturate.
REQ-024 If the counter reaches TIMEOUT_CYC with no response, the FSM SHALL return to IDLE; the owner gets resp_valid=1 with resp_data=0, and arb_timeout pulses in that same cycle.
REQ-025 mem_resp_valid in IDLE or REQ, and any late response after a timeout, SHALL be ignored.
REQ-026 resp_data SHALL hold its last value when resp_valid=0.
REQ-027 If ifu and lsu are both valid in IDLE, the winner SHALL be selected per REQ-033/REQ-034.

Reset
REQ-028 rst=1 at any rising edge SHALL force state IDLE and clear the counter, latched owner, latched address and the round-robin pointer (pointer value: ifu last served).
REQ-029 Reset SHALL force all outputs to 0: req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr and arb_timeout.
REQ-030 Reset during REQ or RESP SHALL abandon the transaction with no resp_valid pulse.
REQ-031 A mem_resp_valid arriving after such a reset SHALL be ignored.
REQ-032 While rst=1, req_ready SHALL be 0 regardless of req_valid.

Configuration
REQ-033 With macro YSYX_22050078_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: the requester not served last wins, and the pointer updates on every grant.
REQ-034 With YSYX_22050078_ARB_RR_EN undefined, simultaneous requests SHALL be granted with fixed priority: lsu always wins, no pointer register exists, and ifu may starve under continuous lsu traffic.

Verification
REQ-035 Single ifu fetch: ifu addr 0x80000000 at T, mem ready at T+1, resp 0x00000413 at T+2 -> ifu_resp_valid=1 and data 0x00000413 at T+3 only; lsu_resp_valid stays 0.
REQ-036 Simultaneous ifu 0x80000004 / lsu 0x80001000 in IDLE, macro undefined -> lsu granted first and ifu second; macro defined after an lsu grant -> ifu granted first.
REQ-037 Backpressure: mem_req_ready low 10 cycles -> mem_req_valid held with mem_req_addr stable 0x80000008, no timeout, req_ready 0 throughout.
REQ-038 Timeout with TIMEOUT_CYC=4: no mem_resp_valid -> owner resp_valid=1 with data 0 and arb_timeout=1 on the 4th RESP cycle; a response 2 cycles later is ignored.
REQ-039 Reset mid-RESP: rst=1 for one cycle, then mem_resp_valid=1 -> no resp_valid on either side; outputs 0; next request accepted normally.
